// File: rtl/lisnoc_dma_initiator_wbreq_pkg.sv
// ---------------------------------------------------------------------------
// lisnoc_dma_initiator_wbreq_pkg
// Shared definitions for the DMA initiator Wishbone read-request stage:
//   - state_t   : FSM encoding (IDLE=00, READ=01, STALL=10)
//   - CTI_*     : Wishbone cycle type identifiers
// No ports (package).
// ---------------------------------------------------------------------------
package lisnoc_dma_initiator_wbreq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_STALL = 2'b10
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

endpackage

// File: rtl/lisnoc_dma_buffer.sv
// ---------------------------------------------------------------------------
// lisnoc_dma_buffer
// First-word-fall-through FIFO used to hand Wishbone read data to the NoC
// request stage.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   i_push, i_data   : write request and data (accepted when not full, or
//                      when a pop happens in the same cycle)
//   i_pop            : pop the head word (ignored when empty)
//   o_data           : head word (valid while !o_empty)
//   o_empty, o_full  : occupancy flags
//   o_almost_full    : exactly one free entry left
// ---------------------------------------------------------------------------
module lisnoc_dma_buffer #(
    parameter int DEPTH = 16,
    parameter int PTRW  = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_almost_full
);

    localparam logic [PTRW:0] C_DEPTH  = (PTRW+1)'(DEPTH);
    localparam logic [PTRW:0] C_DEPTH1 = (PTRW+1)'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTRW-1:0]  r_wptr;
    logic [PTRW-1:0]  r_rptr;
    logic [PTRW:0]    r_count;

    logic w_pop;
    logic w_push;

    assign o_empty       = (r_count == '0);
    assign o_full        = (r_count == C_DEPTH);
    assign o_almost_full = (r_count == C_DEPTH1);
    assign o_data        = r_mem[r_rptr];

    // A full FIFO still accepts a push if the head leaves in the same cycle.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && o_full && !i_pop));

endmodule

// File: rtl/lisnoc_dma_initiator_wbreq.sv
// ---------------------------------------------------------------------------
// lisnoc_dma_initiator_wbreq
// Wishbone master that reads req_size words from local memory for an L2R
// DMA request and hands them to the NoC request stage through a FWFT FIFO.
// Optional feature macro: LISNOC_DMA_WB_BURST_EN (incrementing bursts).
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   req_start, req_is_l2r    : start pulse and direction of the request
//   req_laddr, req_size      : local word-aligned byte address, word count
//   req_data_valid/ready/data: FIFO head handshake towards the NoC stage
//                              (word transfers on a cycle where both valid
//                              and ready are high; valid never waits on
//                              ready)
//   req_err                  : sticky bus error of the current request
//   wb_*                     : Wishbone read master (one transfer at a time)
// ---------------------------------------------------------------------------
module lisnoc_dma_initiator_wbreq
    import lisnoc_dma_initiator_wbreq_pkg::*;
#(
    parameter int fifo_depth    = 16,
    parameter int fifo_ptrwidth = 4,
    parameter int size_width    = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_start,
    input  logic                  req_is_l2r,
    input  logic [31:0]           req_laddr,
    input  logic [size_width-1:0] req_size,
    output logic                  req_data_valid,
    input  logic                  req_data_ready,
    output logic [31:0]           req_data,
    output logic                  req_err,
    output logic [31:0]           wb_adr_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [3:0]            wb_sel_o,
    output logic [2:0]            wb_cti_o,
    output logic [1:0]            wb_bte_o,
    input  logic [31:0]           wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i
);

`ifdef LISNOC_DMA_WB_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    state_t                r_state;
    state_t                w_state_nxt;
    logic [31:0]           r_laddr;
    logic [size_width-1:0] r_size;
    logic [size_width-1:0] r_cnt;
    logic                  r_err;

    logic        w_empty;
    logic        w_full;
    logic        w_afull;
    logic        w_pop;
    logic        w_stb;
    logic        w_beat;
    logic        w_last;
    logic        w_fill;
    logic        w_accept;
    logic [31:0] w_adr;
    logic [31:0] w_push_data;
    logic [2:0]  w_cti;

    assign w_pop    = req_data_ready & ~w_empty;
    assign w_accept = (r_state == ST_IDLE) & req_start & req_is_l2r;

    // The bus is only driven while there is room for the returned word. A
    // full FIFO in READ can only happen when a new request is accepted while
    // the previous one has not drained yet.
    assign w_stb  = (r_state == ST_READ) & ~w_full;
    assign w_beat = w_stb & (wb_ack_i | wb_err_i);
    assign w_last = ((r_cnt + 1'b1) == r_size);
    // This beat leaves the FIFO full: one free slot now and nothing leaves.
    assign w_fill = w_afull & ~w_pop;

    assign w_adr       = r_laddr + ({{(32-size_width){1'b0}}, r_cnt} << 2);
    assign w_push_data = wb_err_i ? 32'h0 : wb_dat_i;

    always_comb begin
        w_cti = CTI_CLASSIC;
        if (w_stb && BURST_EN) begin
            w_cti = (w_last || w_fill) ? CTI_END : CTI_INCR;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (req_size != '0)) begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (w_full) begin
                    w_state_nxt = ST_STALL;
                end else if (w_beat) begin
                    if (w_last) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_fill || !BURST_EN) begin
                        // Classic mode passes through STALL for one cycle to
                        // drop cyc/stb between words.
                        w_state_nxt = ST_STALL;
                    end
                end
            end
            ST_STALL: begin
                if (!w_full) begin
                    w_state_nxt = ST_READ;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_laddr <= '0;
            r_size  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_laddr <= req_laddr;
                r_size  <= req_size;
                r_cnt   <= '0;
                r_err   <= 1'b0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + 1'b1;
                if (wb_err_i) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    lisnoc_dma_buffer #(
        .DEPTH (fifo_depth),
        .PTRW  (fifo_ptrwidth),
        .WIDTH (32)
    ) u_buffer (
        .clk           (clk),
        .rst_n         (rst),
        .i_push        (w_beat),
        .i_data        (w_push_data),
        .i_pop         (w_pop),
        .o_data        (req_data),
        .o_empty       (w_empty),
        .o_full        (w_full),
        .o_almost_full (w_afull)
    );

    assign req_data_valid = ~w_empty;
    assign req_err        = r_err;
    assign wb_cyc_o       = w_stb;
    assign wb_stb_o       = w_stb;
    assign wb_adr_o       = w_stb ? w_adr : 32'h0;
    assign wb_cti_o       = w_cti;
    assign wb_we_o        = 1'b0;
    assign wb_sel_o       = 4'hf;
    assign wb_bte_o       = 2'b00;

endmodule

// File: tb/tb_lisnoc_dma_initiator_wbreq.sv
module tb_lisnoc_dma_initiator_wbreq;

  localparam int DEPTH = 16;
`ifdef LISNOC_DMA_WB_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        req_start, req_is_l2r, req_data_valid, req_data_ready, req_err;
  logic [31:0] req_laddr, req_data, wb_adr_o, wb_dat_i;
  logic [13:0] req_size;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, wb_err_i;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;

  lisnoc_dma_initiator_wbreq #(.fifo_depth(16), .fifo_ptrwidth(4), .size_width(14)) dut (
    .clk(clk), .rst(rst), .req_start(req_start), .req_is_l2r(req_is_l2r),
    .req_laddr(req_laddr), .req_size(req_size), .req_data_valid(req_data_valid),
    .req_data_ready(req_data_ready), .req_data(req_data), .req_err(req_err),
    .wb_adr_o(wb_adr_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // memory contents seen by the slave
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // behavioural model: request progress + FIFO contents as a queue
  bit          m_busy = 0;
  bit          m_hold = 0;
  bit          m_err = 0;
  int          m_rem = 0;
  int          m_size = 0;
  logic [31:0] m_addr = 0;
  logic [31:0] exp_q[$];

  // stimulus knobs
  int ack_p = 100;
  int ready_mode = 1;   // 0 off (except pop_once), 1 on, 2 random
  bit pop_once = 0;
  int err_idx = -1;
  int err_p = 0;

  // observation logs
  logic [31:0] adr_log[$];
  logic [31:0] pop_log[$];
  logic [2:0]  cti_log[$];
  int beats = 0;
  int pops = 0;

  // slave + per-cycle compare process
  always begin
    bit exp_stb, pop, fill, beat, last, b0, is_err;
    int s0;
    logic [2:0] exp_cti;
    @(negedge clk);
    #1;
    if (!rst) begin
      wb_ack_i = 0; wb_err_i = 0; wb_dat_i = 0; req_data_ready = 0;
      #1;
      chk("rst_cyc", 32'(wb_cyc_o), 0);
      chk("rst_stb", 32'(wb_stb_o), 0);
      chk("rst_adr", wb_adr_o, 0);
      chk("rst_cti", 32'(wb_cti_o), 0);
      chk("rst_valid", 32'(req_data_valid), 0);
      chk("rst_err", 32'(req_err), 0);
      m_busy = 0; m_hold = 0; m_err = 0; m_rem = 0; exp_q.delete();
    end else begin
      wb_ack_i = 0; wb_err_i = 0;
      wb_dat_i = mem(wb_adr_o);
      if (wb_stb_o && $urandom_range(1, 100) <= ack_p) begin
        if ((m_size - m_rem) == err_idx || $urandom_range(1, 100) <= err_p) wb_err_i = 1;
        else wb_ack_i = 1;
      end
      case (ready_mode)
        0: req_data_ready = pop_once;
        1: req_data_ready = 1;
        default: req_data_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      s0 = exp_q.size();
      exp_stb = m_busy && !m_hold && s0 < DEPTH;
      pop = req_data_ready && s0 != 0;
      fill = (s0 == DEPTH - 1) && !pop;
      exp_cti = (!exp_stb || !BURST) ? 3'b000 : ((m_rem == 1 || fill) ? 3'b111 : 3'b010);
      chk("stb", 32'(wb_stb_o), 32'(exp_stb));
      chk("cyc", 32'(wb_cyc_o), 32'(exp_stb));
      if (exp_stb) chk("adr", wb_adr_o, m_addr);
      chk("cti", 32'(wb_cti_o), 32'(exp_cti));
      chk("valid", 32'(req_data_valid), 32'(s0 != 0));
      if (s0 != 0) chk("data", req_data, exp_q[0]);
      chk("req_err", 32'(req_err), 32'(m_err));
      chk("consts", {wb_we_o, wb_sel_o, wb_bte_o}, 32'b0_1111_00);
      // advance model to the state after the coming rising edge
      b0 = m_busy;
      is_err = wb_err_i;
      beat = exp_stb && (wb_ack_i || wb_err_i);
      last = (m_rem == 1);
      if (pop) begin
        pop_log.push_back(exp_q.pop_front());
        pops++;
        pop_once = 0;
      end
      if (beat) begin
        adr_log.push_back(m_addr);
        cti_log.push_back(exp_cti);
        beats++;
        exp_q.push_back(is_err ? 32'h0 : mem(m_addr));
        if (is_err) m_err = 1;
        m_rem--;
        m_addr += 4;
        if (last) begin
          m_busy = 0; m_hold = 0;
        end else begin
          m_hold = !BURST || (exp_q.size() == DEPTH);
        end
      end else if (m_busy) begin
        m_hold = (s0 == DEPTH);
      end
      if (req_start && req_is_l2r && !b0) begin
        m_err = 0;
        m_addr = req_laddr;
        m_size = int'(req_size);
        m_rem = m_size;
        m_busy = (m_size != 0);
        m_hold = 0;
      end
    end
  end

  // driver tasks
  task automatic do_start(input bit l2r, input logic [31:0] a, input int sz);
    @(negedge clk);
    req_start = 1; req_is_l2r = l2r; req_laddr = a; req_size = 14'(sz);
    @(negedge clk);
    req_start = 0;
  endtask

  task automatic wait_done(input int max_cyc);
    int i;
    for (i = 0; i < max_cyc && (m_busy || exp_q.size() != 0); i++) @(negedge clk);
    chk("wait_done_timeout", 32'(m_busy || exp_q.size() != 0), 0);
    @(negedge clk);
  endtask

  task automatic clear_logs();
    adr_log.delete(); pop_log.delete(); cti_log.delete();
    beats = 0; pops = 0;
  endtask

  initial begin
    rst = 0; req_start = 0; req_is_l2r = 0; req_laddr = 0; req_size = 0;
    req_data_ready = 0; wb_ack_i = 0; wb_err_i = 0; wb_dat_i = 0;
    repeat (3) @(negedge clk);
    @(posedge clk); #3 rst = 1;

    // basic 3-word read
    clear_logs();
    do_start(1, 32'h1000, 3);
    wait_done(200);
    chk("t1_beats", beats, 3);
    if (beats == 3) begin
      chk("t1_adr0", adr_log[0], 32'h1000);
      chk("t1_adr1", adr_log[1], 32'h1004);
      chk("t1_adr2", adr_log[2], 32'h1008);
    end
    chk("t1_pops", pops, 3);
    if (pops == 3) begin
      chk("t1_d0", pop_log[0], 32'hDEAD1000);
      chk("t1_d2", pop_log[2], 32'hDEAD1008);
    end
    chk("t1_cyc_idle", 32'(wb_cyc_o), 0);

    // R2L and zero-size are ignored on the bus
    clear_logs();
    do_start(0, 32'h3000, 5);
    do_start(1, 32'h9000, 0);
    repeat (10) @(negedge clk);
    chk("t2_beats", beats, 0);
    chk("t2_valid", 32'(req_data_valid), 0);

    // FIFO fill / stall / release
    clear_logs();
    ready_mode = 0;
    do_start(1, 32'h2000, 20);
    repeat (60) @(negedge clk);
    chk("t3_beats_full", beats, 16);
    chk("t3_valid", 32'(req_data_valid), 1);
`ifdef LISNOC_DMA_WB_BURST_EN
    if (beats == 16) begin
      chk("t3_cti14", 32'(cti_log[14]), 32'h2);
      chk("t3_cti15", 32'(cti_log[15]), 32'h7);
    end
`endif
    pop_once = 1;
    repeat (20) @(negedge clk);
    chk("t3_beats_pop1", beats, 17);
    chk("t3_pops1", pops, 1);
    ready_mode = 1;
    wait_done(400);
    chk("t3_beats", beats, 20);
    chk("t3_pops", pops, 20);
    if (pops == 20) begin
      chk("t3_d16", pop_log[16], 32'hDEAD2040);
      chk("t3_d19", pop_log[19], 32'hDEAD204C);
    end

    // bus error on the second beat
    clear_logs();
    err_idx = 1;
    do_start(1, 32'h4000, 4);
    wait_done(200);
    err_idx = -1;
    chk("t4_pops", pops, 4);
    if (pops == 4) begin
      chk("t4_d1_err", pop_log[1], 32'h0);
      chk("t4_d2", pop_log[2], 32'hDEAD4008);
    end
    chk("t4_err_sticky", 32'(req_err), 1);
    do_start(1, 32'h5000, 1);
    #2 chk("t4_err_cleared", 32'(req_err), 0);
    wait_done(100);

    // reset mid-transfer
    ack_p = 30;
    do_start(1, 32'h6000, 12);
    repeat (6) @(negedge clk);
    @(posedge clk); #3 rst = 0;
    #1;
    chk("t5_cyc", 32'(wb_cyc_o), 0);
    chk("t5_stb", 32'(wb_stb_o), 0);
    chk("t5_valid", 32'(req_data_valid), 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #3 rst = 1;
    ack_p = 100;
    clear_logs();
    do_start(1, 32'h7000, 1);
    wait_done(100);
    chk("t5_pops", pops, 1);
    if (pops == 1) chk("t5_d0", pop_log[0], 32'hDEAD7000);

`ifdef LISNOC_DMA_WB_BURST_EN
    clear_logs();
    do_start(1, 32'h8000, 5);
    wait_done(100);
    chk("b_beats", beats, 5);
    if (beats == 5) begin
      chk("b_cti0", 32'(cti_log[0]), 32'h2);
      chk("b_cti3", 32'(cti_log[3]), 32'h2);
      chk("b_cti4", 32'(cti_log[4]), 32'h7);
      chk("b_adr4", adr_log[4], 32'h8010);
    end
`endif

    // randomized requests, some issued before the previous one drained
    ready_mode = 2;
    for (int i = 0; i < 25; i++) begin
      ack_p = $urandom_range(20, 100);
      err_p = $urandom_range(0, 5);
      do_start(1, (i == 3) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC),
               $urandom_range(1, 40));
      if ($urandom_range(0, 1) == 1) wait_done(3000);
      else repeat ($urandom_range(1, 30)) @(negedge clk);
    end
    err_p = 0;
    wait_done(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
